// File: rtl/uart_tx_serializer.sv
// UART transmitter that pops bytes from a non-showahead FIFO and sends 8N1 frames.
// The FIFO is popped in FETCH, and the byte is latched one cycle later, when the FIFO q is valid.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    fifo_read = 1'b0;
    tx_done   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        fifo_read = 1'b1;
        state_d   = LATCH;
      end
      LATCH: begin
        shift_d = fifo_data;
        tx_d    = 1'b0;
        cnt_d   = '0;
        bit_d   = 3'd0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        // The shift register always holds the next bit to send in bit 0.
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_done = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 4 clocks per bit, with a small byte FIFO model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_uart_tx_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  int underflows = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Non-showahead FIFO: q updates the cycle after a read request.
  always @(posedge clock) begin
    if (fifo_read) begin
      rd_pulses <= rd_pulses + 1;
      if (rd_ptr != wr_ptr) begin
        fifo_data <= mem[rd_ptr % 32];
        rd_ptr    <= rd_ptr + 1;
      end else begin
        underflows <= underflows + 1;
      end
    end
    if (tx_done) done_pulses <= done_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 32] = b;
    wr_ptr++;
  endtask

  // Called at a falling edge with enable high and the FIFO non-empty; the next rising
  // edge starts the fetch. Checks the pop pulse, the 2-edge fall and every frame cycle.
  task automatic send_exact(input logic [7:0] b, input int drop_at, input int abort_at);
    logic [9:0] frame;
    logic       exp_bit;
    frame = {1'b1, b, 1'b0};
    @(negedge clock);
    chk("fetch_read", fifo_read, 1);
    chk("fetch_tx", tx, 1);
    chk("fetch_busy", busy, 1);
    @(negedge clock);
    chk("latch_read", fifo_read, 0);
    chk("latch_tx", tx, 1);
    @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      exp_bit = frame[i / 4];
      chk($sformatf("frame_%02h_tx_c%0d", b, i), tx, exp_bit);
      chk($sformatf("frame_%02h_done_c%0d", b, i), tx_done, (i == 39) ? 1 : 0);
      chk($sformatf("frame_%02h_busy_c%0d", b, i), busy, 1);
      chk($sformatf("frame_%02h_read_c%0d", b, i), fifo_read, 0);
      if (i == drop_at) enable = 1'b0;
      if (i == abort_at) begin
        reset = 1'b0;
        break;
      end
      if (i != 39) @(negedge clock);
    end
  endtask

  initial begin
    int base_rd;
    int base_done;

    // Reset then idle with an empty FIFO, even while enabled.
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read", fifo_read, 0);
    chk("rst_done", tx_done, 0);
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_read", fifo_read, 0);
    end

    // Single byte 0x55.
    base_rd = rd_pulses;
    base_done = done_pulses;
    push(8'h55);
    send_exact(8'h55, -1, -1);
    @(negedge clock);
    chk("single_busy_after", busy, 0);
    chk("single_tx_after", tx, 1);
    chk("single_reads", rd_pulses - base_rd, 1);
    chk("single_dones", done_pulses - base_done, 1);

    // Back-to-back 0xA3, 0x0F with exactly 3 idle-high cycles between frames.
    base_rd = rd_pulses;
    push(8'hA3);
    push(8'h0F);
    send_exact(8'hA3, -1, -1);
    @(negedge clock);
    chk("gap1_tx", tx, 1);
    chk("gap1_busy", busy, 0);
    send_exact(8'h0F, -1, -1);
    @(negedge clock);
    chk("b2b_reads", rd_pulses - base_rd, 2);
    // FIFO went empty while the last byte was in flight: parks in IDLE.
    for (int i = 0; i < 10; i++) begin
      chk("park_read", fifo_read, 0);
      chk("park_busy", busy, 0);
      @(negedge clock);
    end

    // Enable gating: pending bytes, enable low.
    enable = 1'b0;
    push(8'h3C);
    push(8'h99);
    base_rd = rd_pulses;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      chk("gate_read", fifo_read, 0);
      chk("gate_tx", tx, 1);
    end
    enable = 1'b1;
    send_exact(8'h3C, 10, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("blocked_read", fifo_read, 0);
      chk("blocked_busy", busy, 0);
      chk("blocked_tx", tx, 1);
    end
    chk("gate_reads", rd_pulses - base_rd, 1);
    enable = 1'b1;
    send_exact(8'h99, -1, -1);
    @(negedge clock);

    // Reset during bit 3 of 0xFF, then 0x12 goes out after release.
    base_rd = rd_pulses;
    base_done = done_pulses;
    push(8'hFF);
    push(8'h12);
    send_exact(8'hFF, -1, 17);
    @(negedge clock);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", tx_done, 0);
    chk("abort_dones", done_pulses - base_done, 0);
    reset = 1'b1;
    send_exact(8'h12, -1, -1);
    @(negedge clock);
    chk("abort_reads", rd_pulses - base_rd, 2);
    chk("abort_dones_after", done_pulses - base_done, 1);

    // Reset during FETCH: the pop still happens and that byte is lost.
    repeat (3) @(negedge clock);
    base_rd = rd_pulses;
    push(8'h5A);
    push(8'h21);
    @(negedge clock);
    chk("rfetch_read", fifo_read, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("rfetch_busy", busy, 0);
    chk("rfetch_tx", tx, 1);
    reset = 1'b1;
    send_exact(8'h21, -1, -1);
    @(negedge clock);
    chk("rfetch_reads", rd_pulses - base_rd, 2);

    // Refill an empty FIFO with 0x80: fall exactly 2 edges after sampling non-empty.
    repeat (5) @(negedge clock);
    push(8'h80);
    send_exact(8'h80, -1, -1);
    @(negedge clock);
    chk("refill_busy", busy, 0);
    chk("underflows", underflows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  the reset, synchronous and active-low.
REQ-004 The block SHALL have port enable  input  1  the transmit enable, sampled only in IDLE.
REQ-005 The block SHALL have port fifo_empty  input  1  the empty flag from the TX byte FIFO.
REQ-006 The block SHALL have port fifo_data  input  8  the FIFO q, non-showahead, valid the cycle after a read.
REQ-007 The block SHALL have port fifo_read  output  1  the FIFO rdreq, a one-cycle pop pulse.
REQ-008 The block SHALL have port tx  output  1  the serial line, idle high, registered.
REQ-009 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 The block SHALL have port tx_done  output  1  a one-cycle pulse at the end of each stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, LATCH, START, DATA and STOP, with fifo_read=1 only in FETCH.
REQ-012 IDLE SHALL go to FETCH when enable=1 and fifo_empty=0 at a clock edge, and stay in IDLE otherwise.
REQ-013 FETCH SHALL last exactly one cycle and go to LATCH unconditionally.
REQ-014 LATCH SHALL capture fifo_data into the 8-bit shift register, set tx=0, clear the baud counter and go to START.
REQ-015 In START, tx SHALL stay 0 for CLKS_PER_BIT cycles, then go to DATA with tx = shift[0].
REQ-016 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index that increments at each bit boundary.
REQ-017 After bit 7 completes, the FSM SHALL go to STOP with tx=1.
REQ-018 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, pulse tx_done during its last cycle, then return to IDLE.
REQ-019 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and reset to 0 at every bit boundary with no drift or wrap error.
REQ-020 The falling edge of tx SHALL occur 2 clock edges after the edge at which IDLE first samples enable=1 and fifo_empty=0.
REQ-021 One frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from the fall of tx to the end of the stop bit.
REQ-022 Back-to-back frames SHALL have exactly 3 extra idle-high cycles between the end of a stop bit and the next start bit.
REQ-023 fifo_read SHALL never assert while fifo_empty=1 is sampled in IDLE, so the FIFO can never underflow.
REQ-024 The block SHALL never assert fifo_read twice per frame.
REQ-025 Deasserting enable outside IDLE SHALL have no effect: the current frame completes and the next frame is blocked.
REQ-026 fifo_empty changes outside IDLE SHALL be ignored.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL set state=IDLE, tx=1, fifo_read=0, busy=0, tx_done=0, shift register=0, baud counter=0 and bit index=0.
REQ-028 A reset applied mid-frame SHALL abort the frame, drive tx high from the next edge and discard the byte without re-reading it.
REQ-029 A reset during FETCH SHALL still let the FIFO pop occur, and that byte SHALL be lost.
REQ-030 After reset is released, the block SHALL wait at least one IDLE cycle before fetching.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset then idle: reset=0 for 3 cycles, release, fifo_empty=1 -> tx=1, busy=0 and fifo_read=0 for 100 cycles.
REQ-032 Single byte: FIFO holds 0x55, enable=1 -> one fifo_read pulse, and tx = 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles.
REQ-033 Single byte (continued): tx_done pulses once, 40 cycles after tx falls minus 1, and busy falls the next cycle.
REQ-034 Back-to-back: FIFO holds 0xA3, 0x0F -> LSB-first frames 0,1,1,0,0,0,1,0,1,1 and 0,1,1,1,1,0,0,0,0,1 separated by exactly 3 idle-high cycles, with two fifo_read pulses total.
REQ-035 Enable gating: FIFO non-empty, enable=0 for 50 cycles -> no fifo_read and tx=1.
REQ-036 Enable gating (continued): enable dropped mid-frame -> that frame completes and no further fetch occurs.
REQ-037 Reset mid-frame: reset=0 during bit 3 of 0xFF -> tx=1 at the next edge, busy=0, tx_done never pulses.
REQ-038 Reset mid-frame (continued): the following FIFO byte 0x12 transmits correctly after release.
REQ-039 Empty boundary: the FIFO goes empty while the last byte is in flight -> the FSM parks in IDLE with no further fifo_read.
REQ-040 Empty boundary (continued): refilling the FIFO with 0x80 -> tx falls exactly 2 edges after fifo_empty is sampled low in IDLE.
